// File: rtl/dcpu16_marb.sv
// dcpu16_marb: merges the DCPU16 F-BUS (read/write) and G-BUS (read-only)
// onto one simplified-Wishbone memory port, with a no-ack watchdog.
//
// Handshake: a master raises stb and holds its address/data until it sees
// ack. The ack is a one-cycle pulse taken combinationally from the memory's
// m_ack so the core's stall rule (ena = stb ~^ ack) stays exact. The memory
// side is a registered m_stb that stays high for the whole grant and drops on
// the edge that closes it. m_ack only counts while a grant is open.
module dcpu16_marb #(
    parameter int PRI = 0,   // tie-break: 0 = round-robin, 1 = F-BUS fixed priority
    parameter int TMO = 16,  // no-ack timeout in cycles, 0 disables the watchdog
    parameter int TW  = 5    // timeout counter width, 2**TW > TMO
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] f_adr,
    input  logic        f_stb,
    input  logic        f_wre,
    input  logic [15:0] f_dto,
    output logic [15:0] f_dti,
    output logic        f_ack,
    input  logic [15:0] g_adr,
    input  logic        g_stb,
    output logic [15:0] g_dti,
    output logic        g_ack,
    output logic [15:0] m_adr,
    output logic        m_stb,
    output logic        m_wre,
    output logic [15:0] m_dto,
    input  logic [15:0] m_dti,
    input  logic        m_ack,
    output logic        err,
    output logic        err_flag,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GNTF = 2'd1,
        S_GNTG = 2'd2,
        S_BUBL = 2'd3
    } state_t;

    // Last count value before the watchdog fires; unused when TMO is 0.
    localparam logic [TW-1:0] TCNT_LAST = TW'((TMO > 0) ? (TMO - 1) : 0);
    localparam logic [TW-1:0] TCNT_MAX  = {TW{1'b1}};

    state_t        r_state;
    state_t        w_next;
    logic          r_lst_g;     // 1 = G-BUS was served last
    logic [TW-1:0] r_tcnt;
    logic          r_err_flag;

    logic          w_in_gnt;
    logic          w_tmo_hit;
    logic          w_done;
    logic          w_pick_f;
    logic          w_pick_g;

    assign w_in_gnt  = (r_state == S_GNTF) || (r_state == S_GNTG);
    // The watchdog only fires when the slave is silent in the last allowed cycle.
    assign w_tmo_hit = (TMO != 0) && w_in_gnt && !m_ack && (r_tcnt == TCNT_LAST);
    assign w_done    = w_in_gnt && (m_ack || w_tmo_hit);
    // F wins alone, on fixed priority, or when G was the last one served.
    assign w_pick_f  = f_stb && (!g_stb || (PRI != 0) || r_lst_g);
    assign w_pick_g  = g_stb && !w_pick_f;

    assign err_flag  = r_err_flag;
    assign dbg_state = r_state;

    // Next-state selection and the combinational master-side responses.
    always_comb begin
        w_next = r_state;
        f_ack  = 1'b0;
        g_ack  = 1'b0;
        err    = 1'b0;
        f_dti  = w_tmo_hit ? 16'h0000 : m_dti;
        g_dti  = w_tmo_hit ? 16'h0000 : m_dti;
        case (r_state)
            S_IDLE: begin
                if (w_pick_f)      w_next = S_GNTF;
                else if (w_pick_g) w_next = S_GNTG;
            end
            S_GNTF: begin
                f_ack = w_done && !rst;
                err   = w_tmo_hit && !rst;
                if (w_done) w_next = S_BUBL;
            end
            S_GNTG: begin
                g_ack = w_done && !rst;
                err   = w_tmo_hit && !rst;
                if (w_done) w_next = S_BUBL;
            end
            S_BUBL: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Memory-port registers, last-served pointer, watchdog counter and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_adr      <= 16'h0000;
            m_stb      <= 1'b0;
            m_wre      <= 1'b0;
            m_dto      <= 16'h0000;
            r_lst_g    <= 1'b1;
            r_tcnt     <= '0;
            r_err_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pick_f) begin
                        m_adr  <= f_adr;
                        m_wre  <= f_wre;
                        m_dto  <= f_dto;
                        m_stb  <= 1'b1;
                        r_tcnt <= '0;
                    end else if (w_pick_g) begin
                        m_adr  <= g_adr;
                        m_wre  <= 1'b0;
                        m_dto  <= 16'h0000;
                        m_stb  <= 1'b1;
                        r_tcnt <= '0;
                    end
                end
                S_GNTF, S_GNTG: begin
                    if (w_done) begin
                        m_stb   <= 1'b0;
                        m_wre   <= 1'b0;
                        r_lst_g <= (r_state == S_GNTG);
                        if (w_tmo_hit) r_err_flag <= 1'b1;
                    end else if (r_tcnt != TCNT_MAX) begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcpu16_marb.sv
// Bench for dcpu16_marb: two instances (round-robin with an 8-cycle watchdog,
// and fixed F priority with the watchdog off), a scripted slave per instance,
// a transaction-level reference model and directed scenarios.
module tb_dcpu16_marb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [15:0] f_adr [2];
  logic [15:0] f_dto [2];
  logic [15:0] g_adr [2];
  logic [15:0] m_dti [2];
  logic        f_stb [2];
  logic        f_wre [2];
  logic        g_stb [2];
  logic        m_ack [2];
  logic [15:0] f_dti [2];
  logic [15:0] g_dti [2];
  logic [15:0] m_adr [2];
  logic [15:0] m_dto [2];
  logic        f_ack [2];
  logic        g_ack [2];
  logic        m_stb [2];
  logic        m_wre [2];
  logic        err [2];
  logic        err_flag [2];
  logic [1:0]  dbg_state [2];

  dcpu16_marb #(.PRI(0), .TMO(8), .TW(4)) dut0 (
    .clk(clk), .rst(rst),
    .f_adr(f_adr[0]), .f_stb(f_stb[0]), .f_wre(f_wre[0]), .f_dto(f_dto[0]),
    .f_dti(f_dti[0]), .f_ack(f_ack[0]),
    .g_adr(g_adr[0]), .g_stb(g_stb[0]), .g_dti(g_dti[0]), .g_ack(g_ack[0]),
    .m_adr(m_adr[0]), .m_stb(m_stb[0]), .m_wre(m_wre[0]), .m_dto(m_dto[0]),
    .m_dti(m_dti[0]), .m_ack(m_ack[0]),
    .err(err[0]), .err_flag(err_flag[0]), .dbg_state(dbg_state[0])
  );

  dcpu16_marb #(.PRI(1), .TMO(0), .TW(5)) dut1 (
    .clk(clk), .rst(rst),
    .f_adr(f_adr[1]), .f_stb(f_stb[1]), .f_wre(f_wre[1]), .f_dto(f_dto[1]),
    .f_dti(f_dti[1]), .f_ack(f_ack[1]),
    .g_adr(g_adr[1]), .g_stb(g_stb[1]), .g_dti(g_dti[1]), .g_ack(g_ack[1]),
    .m_adr(m_adr[1]), .m_stb(m_stb[1]), .m_wre(m_wre[1]), .m_dto(m_dto[1]),
    .m_dti(m_dti[1]), .m_ack(m_ack[1]),
    .err(err[1]), .err_flag(err_flag[1]), .dbg_state(dbg_state[1])
  );

  function automatic int pri_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  function automatic int tmo_of(input int d);
    return (d == 0) ? 8 : 0;
  endfunction

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%h expected=%h at t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- scripted slave: ack after sdelay cycles of m_stb ----------------
  int          sdelay [2];
  logic [15:0] sdata [2];
  logic        force_ack [2];
  int          scnt [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_ack[d] = 1'b0;
      m_dti[d] = 16'h0000;
      scnt[d]  = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int d = 0; d < 2; d++) begin
        scnt[d]  = (m_stb[d] === 1'b1) ? scnt[d] + 1 : 0;
        m_ack[d] = force_ack[d] ||
                   ((m_stb[d] === 1'b1) && (sdelay[d] != 0) && (scnt[d] == sdelay[d]));
        m_dti[d] = sdata[d];
      end
    end
  end

  // ---------------- reference model: one open transaction per instance ----------------
  logic        busy [2];
  logic        who_g [2];
  logic        bub [2];
  logic        lst_g [2];
  logic        flag [2];
  int          age [2];
  logic [15:0] e_adr [2];
  logic [15:0] e_dto [2];
  logic        e_wre [2];

  function automatic logic tmo_now(input int d);
    return (tmo_of(d) > 0) && busy[d] && (age[d] == tmo_of(d) - 1) && !m_ack[d];
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy[d]  <= 1'b0;
        bub[d]   <= 1'b0;
        lst_g[d] <= 1'b1;
        flag[d]  <= 1'b0;
        age[d]   <= 0;
      end else if (busy[d]) begin
        if (m_ack[d] || tmo_now(d)) begin
          busy[d]  <= 1'b0;
          bub[d]   <= 1'b1;
          lst_g[d] <= who_g[d];
          if (tmo_now(d)) flag[d] <= 1'b1;
        end else begin
          age[d] <= age[d] + 1;
        end
      end else if (bub[d]) begin
        bub[d] <= 1'b0;
      end else if (f_stb[d] || g_stb[d]) begin
        logic take_f;
        take_f = f_stb[d] && (!g_stb[d] || pri_of(d) == 1 || lst_g[d]);
        busy[d]  <= 1'b1;
        age[d]   <= 0;
        who_g[d] <= !take_f;
        e_adr[d] <= take_f ? f_adr[d] : g_adr[d];
        e_wre[d] <= take_f ? f_wre[d] : 1'b0;
        e_dto[d] <= take_f ? f_dto[d] : 16'h0000;
      end
    end
  end

  // ---------------- compare process: every cycle, mid-cycle ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic ev;
      logic to;
      to = tmo_now(d);
      ev = !rst && busy[d] && (m_ack[d] || to);
      chk("f_ack", d, f_ack[d], ev && !who_g[d]);
      chk("g_ack", d, g_ack[d], ev && who_g[d]);
      if (ev && !who_g[d]) chk("f_dti", d, f_dti[d], to ? 16'h0000 : m_dti[d]);
      if (ev && who_g[d])  chk("g_dti", d, g_dti[d], to ? 16'h0000 : m_dti[d]);
      chk("m_stb", d, m_stb[d], busy[d]);
      chk("m_wre", d, m_wre[d], busy[d] && e_wre[d]);
      if (busy[d]) begin
        chk("m_adr", d, m_adr[d], e_adr[d]);
        chk("m_dto", d, m_dto[d], e_dto[d]);
      end
      chk("err", d, err[d], !rst && to);
      chk("err_flag", d, err_flag[d], flag[d]);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits up to lim negedges for an ack; cyc is the negedge count, -1 if none.
  task automatic wait_ack(input int d, input bit g, input int lim, output int cyc);
    cyc = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if ((g ? g_ack[d] : f_ack[d]) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  int cyc;
  int cnt_a;
  int cnt_b;
  int ord [$];
  int gap [$];

  initial begin : main
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      f_adr[d] = 16'h0; f_dto[d] = 16'h0; g_adr[d] = 16'h0;
      f_stb[d] = 1'b0;  f_wre[d] = 1'b0;  g_stb[d] = 1'b0;
      sdelay[d] = 0; sdata[d] = 16'h0; force_ack[d] = 1'b0;
    end
    step(); step(); step();
    @(negedge clk);
    chk("rst_m_adr", 0, m_adr[0], 16'h0000);
    chk("rst_m_stb", 1, m_stb[1], 1'b0);
    chk("rst_err_flag", 0, err_flag[0], 1'b0);
    step();
    rst = 1'b0;
    step();

    // 1: F read alone, slave acks in the third m_stb cycle
    sdelay[0] = 3; sdata[0] = 16'hBEEF;
    f_adr[0] = 16'h0100; f_wre[0] = 1'b0; f_stb[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_m_adr", 0, m_adr[0], 16'h0100);
    chk("t1_m_wre", 0, m_wre[0], 1'b0);
    chk("t1_m_stb", 0, m_stb[0], 1'b1);
    wait_ack(0, 1'b0, 20, cyc);
    chk("t1_ack_cycle", 0, cyc, 2);
    chk("t1_f_dti", 0, f_dti[0], 16'hBEEF);
    step();
    f_stb[0] = 1'b0;
    @(negedge clk);
    chk("t1_bubble_stb", 0, m_stb[0], 1'b0);
    step(); step();

    // 2: round-robin after reset, both masters requesting continuously
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    sdelay[0] = 2; sdata[0] = 16'h5A5A;
    f_adr[0] = 16'h0011; g_adr[0] = 16'h0022;
    f_stb[0] = 1'b1; g_stb[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int n;
      n = -1;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (f_ack[0] === 1'b1 || g_ack[0] === 1'b1) begin
          n = i;
          break;
        end
      end
      ord.push_back((g_ack[0] === 1'b1) ? 1 : 0);
      gap.push_back(n);
    end
    step();
    f_stb[0] = 1'b0; g_stb[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t2_order", k, ord[k], k % 2);
      chk("t2_spacing", k, gap[k], (k == 0) ? 3 : 4);
    end
    step(); step();

    // 3: fixed F priority, then G after F drops
    sdelay[1] = 1; sdata[1] = 16'h1111;
    f_adr[1] = 16'h0A0A; g_adr[1] = 16'h0B0B;
    f_stb[1] = 1'b1; g_stb[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1, 1'b0, 12, cyc);
      chk("t3_f_wins", k, cyc, (k == 0) ? 2 : 3);
    end
    step();
    f_stb[1] = 1'b0;
    wait_ack(1, 1'b1, 12, cyc);
    chk("t3_g_after_drop", 1, cyc, 3);
    chk("t3_g_adr", 1, m_adr[1], 16'h0B0B);
    chk("t3_g_dti", 1, g_dti[1], 16'h1111);
    step();
    g_stb[1] = 1'b0;
    step(); step();

    // 4: F write with a G request arriving mid-grant
    sdelay[0] = 4; sdata[0] = 16'hC0DE;
    f_adr[0] = 16'h8000; f_dto[0] = 16'h1234; f_wre[0] = 1'b1; g_adr[0] = 16'h0040;
    f_stb[0] = 1'b1;
    step();
    g_stb[0] = 1'b1;
    @(negedge clk);
    chk("t4_m_wre", 0, m_wre[0], 1'b1);
    chk("t4_m_dto", 0, m_dto[0], 16'h1234);
    chk("t4_m_adr", 0, m_adr[0], 16'h8000);
    wait_ack(0, 1'b0, 12, cyc);
    chk("t4_f_ack_cycle", 0, cyc, 3);
    step();
    f_stb[0] = 1'b0; f_wre[0] = 1'b0;
    wait_ack(0, 1'b1, 16, cyc);
    chk("t4_g_ack_cycle", 0, cyc, 6);
    chk("t4_g_adr", 0, m_adr[0], 16'h0040);
    chk("t4_g_dti", 0, g_dti[0], 16'hC0DE);
    step();
    g_stb[0] = 1'b0;
    step(); step();

    // 5: watchdog with TMO=8, slave silent, then a late ack
    sdelay[0] = 0; sdata[0] = 16'hFFFF;
    f_adr[0] = 16'h0200; f_wre[0] = 1'b0; f_stb[0] = 1'b1;
    cnt_a = 0; cnt_b = 0; cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (m_stb[0] === 1'b1) cnt_a++;
      if (err[0] === 1'b1) cnt_b++;
      if (f_ack[0] === 1'b1) begin
        cyc = i;
        break;
      end
    end
    chk("t5_stb_cycles", 0, cnt_a, 8);
    chk("t5_tmo_ack_seen", 0, cyc, 9);
    chk("t5_f_dti_zero", 0, f_dti[0], 16'h0000);
    chk("t5_err_pulse", 0, err[0], 1'b1);
    chk("t5_flag_not_yet", 0, err_flag[0], 1'b0);
    step();
    f_stb[0] = 1'b0; force_ack[0] = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (f_ack[0] === 1'b1 || g_ack[0] === 1'b1) cnt_a++;
      if (err[0] === 1'b1) cnt_b++;
    end
    chk("t5_late_ack_ignored", 0, cnt_a, 0);
    chk("t5_err_count", 0, cnt_b, 1);
    chk("t5_flag_sticky", 0, err_flag[0], 1'b1);
    step();
    force_ack[0] = 1'b0;
    step();

    // TMO=0: a grant waits forever until the slave answers
    sdelay[1] = 0; sdata[1] = 16'h7777;
    g_adr[1] = 16'h0300; g_stb[1] = 1'b1;
    cnt_a = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (g_ack[1] === 1'b1) cnt_a++;
    end
    chk("tmo0_no_ack", 1, cnt_a, 0);
    chk("tmo0_stb_held", 1, m_stb[1], 1'b1);
    step();
    force_ack[1] = 1'b1;
    @(negedge clk);
    chk("tmo0_ack", 1, g_ack[1], 1'b1);
    chk("tmo0_g_dti", 1, g_dti[1], 16'h7777);
    step();
    force_ack[1] = 1'b0; g_stb[1] = 1'b0;
    step(); step();

    // 6: reset one cycle into a G grant while the slave acks
    sdelay[0] = 0;
    g_adr[0] = 16'h0600; g_stb[0] = 1'b1;
    step();
    rst = 1'b1; force_ack[0] = 1'b1;
    @(negedge clk);
    chk("t6_no_ack_in_rst", 0, g_ack[0], 1'b0);
    chk("t6_stb_before_edge", 0, m_stb[0], 1'b1);
    step();
    @(negedge clk);
    chk("t6_stb_cleared", 0, m_stb[0], 1'b0);
    chk("t6_idle", 0, dbg_state[0], 2'd0);
    chk("t6_flag_cleared", 0, err_flag[0], 1'b0);
    step();
    rst = 1'b0; force_ack[0] = 1'b0; g_stb[0] = 1'b0;
    step();
    sdelay[0] = 2; sdata[0] = 16'h2468;
    f_adr[0] = 16'h0700; f_stb[0] = 1'b1;
    wait_ack(0, 1'b0, 12, cyc);
    chk("t6_regrant_cycle", 0, cyc, 3);
    chk("t6_f_dti", 0, f_dti[0], 16'h2468);
    step();
    f_stb[0] = 1'b0;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
